// File: rtl/mips_multi_cycle.sv
// Multi-cycle MIPS-I subset core with unified word memory, debug register read port and loader port.
// Optional feature: define MIPS_MC_SLT_EN to enable R-type slt (funct 0x2A).
module mips_multi_cycle #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter logic [31:0] PC_RESET  = 32'h0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         prog_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] prog_addr,
    input  logic [31:0]                  prog_data,
    input  logic [4:0]                   dbg_sel,
    output logic [31:0]                  dbg_data,
    output logic [31:0]                  pc,
    output logic [3:0]                   state,
    output logic                         retired,
    output logic                         halt
);
    localparam int unsigned AW = $clog2(MEM_DEPTH);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WB   = 4'd6,
        MEM_WR   = 4'd7,
        ALU_WB   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        HALT     = 4'd11
    } state_t;

    state_t      cur;
    logic [31:0] mem [MEM_DEPTH];
    logic [31:0] rf  [32];
    logic [31:0] ir;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] alu_out;
    logic [31:0] mdr;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        unused_shamt;

    assign opcode       = ir[31:26];
    assign rs           = ir[25:21];
    assign rt           = ir[20:16];
    assign rd           = ir[15:11];
    assign funct        = ir[5:0];
    assign unused_shamt = ^ir[10:6];

    assign state    = cur;
    assign dbg_data = (dbg_sel == 5'd0) ? 32'd0 : rf[dbg_sel];

    // Decode legality; anything outside the subset parks the core in HALT.
    logic supported_c;
    always_comb begin
        supported_c = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR: supported_c = 1'b1;
`ifdef MIPS_MC_SLT_EN
                    FN_SLT:                        supported_c = 1'b1;
`endif
                    default:                       supported_c = 1'b0;
                endcase
            end
            OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: supported_c = 1'b1;
            default:                             supported_c = 1'b0;
        endcase
    end

    logic [31:0] r_result_c;
    always_comb begin
        r_result_c = 32'd0;
        case (funct)
            FN_ADD:  r_result_c = a + b;
            FN_SUB:  r_result_c = a - b;
            FN_AND:  r_result_c = a & b;
            FN_OR:   r_result_c = a | b;
`ifdef MIPS_MC_SLT_EN
            FN_SLT:  r_result_c = {31'd0, ($signed(a) < $signed(b))};
`endif
            default: r_result_c = 32'd0;
        endcase
    end

    // Register write-back: lw targets rt, R-type targets rd, addi targets rt.
    logic        rf_we_c;
    logic [4:0]  rf_waddr_c;
    logic [31:0] rf_wdata_c;
    always_comb begin
        rf_we_c    = 1'b0;
        rf_waddr_c = rt;
        rf_wdata_c = alu_out;
        if (cur == MEM_WB) begin
            rf_we_c    = 1'b1;
            rf_wdata_c = mdr;
        end else if (cur == ALU_WB) begin
            rf_we_c    = 1'b1;
            rf_waddr_c = (opcode == OP_RTYPE) ? rd : rt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else if (rf_we_c && (rf_waddr_c != 5'd0)) begin
            rf[rf_waddr_c] <= rf_wdata_c;
        end
    end

    // Memory survives reset; the loader may only write while reset is held or the core is halted.
    logic prog_ok;
    assign prog_ok = prog_we && (!reset || halt);

    always_ff @(posedge clk) begin
        if (prog_ok) begin
            mem[prog_addr] <= prog_data;
        end else if (reset && (cur == MEM_WR)) begin
            mem[alu_out[AW+1:2]] <= b;
        end
    end

    // Control FSM; retired is raised on entry to each instruction's final state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur     <= FETCH;
            pc      <= PC_RESET;
            retired <= 1'b0;
            halt    <= 1'b0;
            ir      <= 32'd0;
            a       <= 32'd0;
            b       <= 32'd0;
            imm     <= 32'd0;
            alu_out <= 32'd0;
            mdr     <= 32'd0;
        end else begin
            retired <= 1'b0;
            unique case (cur)
                FETCH: begin
                    ir  <= mem[pc[AW+1:2]];
                    pc  <= pc + 32'd4;
                    cur <= DECODE;
                end
                DECODE: begin
                    a   <= rf[rs];
                    b   <= rf[rt];
                    imm <= {{16{ir[15]}}, ir[15:0]};
                    if (!supported_c) begin
                        cur  <= HALT;
                        halt <= 1'b1;
                    end else begin
                        case (opcode)
                            OP_RTYPE: cur <= EXEC_R;
                            OP_ADDI:  cur <= EXEC_I;
                            OP_BEQ: begin
                                cur     <= BRANCH;
                                retired <= 1'b1;
                            end
                            OP_J: begin
                                cur     <= JUMP;
                                retired <= 1'b1;
                            end
                            default:  cur <= MEM_ADDR;
                        endcase
                    end
                end
                EXEC_R: begin
                    alu_out <= r_result_c;
                    cur     <= ALU_WB;
                    retired <= 1'b1;
                end
                EXEC_I: begin
                    alu_out <= a + imm;
                    cur     <= ALU_WB;
                    retired <= 1'b1;
                end
                MEM_ADDR: begin
                    alu_out <= a + imm;
                    if (opcode == OP_LW) begin
                        cur <= MEM_RD;
                    end else begin
                        cur     <= MEM_WR;
                        retired <= 1'b1;
                    end
                end
                MEM_RD: begin
                    mdr     <= mem[alu_out[AW+1:2]];
                    cur     <= MEM_WB;
                    retired <= 1'b1;
                end
                MEM_WB, MEM_WR, ALU_WB: cur <= FETCH;
                BRANCH: begin
                    if (a == b) pc <= pc + (imm << 2);
                    cur <= FETCH;
                end
                JUMP: begin
                    pc  <= {pc[31:28], ir[25:0], 2'b00};
                    cur <= FETCH;
                end
                HALT: begin
                    cur  <= HALT;
                    halt <= 1'b1;
                end
                default: cur <= FETCH;
            endcase
        end
    end
endmodule

// File: doc/mips_multi_cycle.md
MIPS_MULTI_CYCLE -- requirements
Module: mips_multi_cycle

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 256: unified instruction/data memory size in 32-bit words; power of two, 16..4096.
REQ-002 The block SHALL have parameter PC_RESET, default 32'h0: PC value loaded on reset; word-aligned.
REQ-003 The block SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset  input  1: asynchronous, active-low reset; asserted when 0.
REQ-005 The block SHALL have port prog_we  input  1: bench/loader memory write strobe.
REQ-006 The block SHALL have port prog_addr  input  clog2(MEM_DEPTH): word index for prog_we.
REQ-007 The block SHALL have port prog_data  input  32: word written by prog_we.
REQ-008 The block SHALL have port dbg_sel  input  5: register-file index for combinational debug read.
REQ-009 The block SHALL have port dbg_data  output  32: reg_file[dbg_sel]; 0 when dbg_sel=0.
REQ-010 The block SHALL have port pc  output  32: current PC.
REQ-011 The block SHALL have port state  output  4: current FSM state encoding.
REQ-012 The block SHALL have port retired  output  1: one-cycle pulse per completed instruction.
REQ-013 The block SHALL have port halt  output  1: high while in HALT.

Function
REQ-014 The block SHALL be a multi-cycle MIPS-I subset core: add, sub, and, or (R-type), addi, lw, sw, beq, j.
REQ-015 The FSM SHALL use states FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, ALU_WB, BRANCH, JUMP, HALT.
REQ-016 FETCH SHALL latch IR=mem[pc[ADDR+1:2]] and set pc=pc+4; DECODE SHALL latch A=rs, B=rt and sign-extended imm.
REQ-017 Latency SHALL be: R-type/addi 4 cycles (FETCH,DECODE,EXEC,ALU_WB); lw 5 (FETCH,DECODE,MEM_ADDR,MEM_RD,MEM_WB); sw 4 (..,MEM_ADDR,MEM_WR); beq and j 3.
REQ-018 retired SHALL pulse in the final state of each instruction, then the FSM SHALL return to FETCH.
REQ-019 beq SHALL set pc=pc+4+(sext(imm)<<2) when A==B, else leave pc unchanged; j SHALL set pc={pc[31:28],imm26,2'b00}.
REQ-020 Arithmetic SHALL be 32-bit two's complement, wrapping silently; no overflow trap.
REQ-021 Writes to register 0 SHALL be discarded; reads of register 0 SHALL return 0.
REQ-022 Memory addresses SHALL use byte bits [clog2(MEM_DEPTH)+1:2]; higher bits ignored (wrap modulo MEM_DEPTH); bits [1:0] ignored.
REQ-023 An unsupported opcode/funct in DECODE SHALL enter HALT; HALT SHALL persist until reset, no retired pulse.
REQ-024 prog_we SHALL write memory only while reset is asserted or halt=1; otherwise ignored.
REQ-025 A j to its own address SHALL loop indefinitely, retiring every 3 cycles.

Reset
REQ-026 Reset assertion SHALL immediately force pc=PC_RESET, state=FETCH, retired=0, halt=0, IR/A/B=0, all 32 registers 0, independent of clk.
REQ-027 Memory contents SHALL NOT be affected by reset; reset mid-instruction SHALL abandon it with no register or memory write.
REQ-028 First FETCH SHALL occur on the first rising clk edge after reset deasserts.

Configuration
REQ-029 With MIPS_MC_SLT_EN defined, R-type funct 0x2A (slt) SHALL write 1 to rd if signed A<B else 0, 4-cycle latency.
REQ-030 Without MIPS_MC_SLT_EN, funct 0x2A SHALL be unsupported and enter HALT per REQ-023.

Verification
REQ-031 Load 20090005, 200A000A, 012A4020 at words 0..2, release reset -> t1=5 after cycle 4, t2=10 after cycle 8, t0=0x0000000F after cycle 12.
REQ-032 Then 012A4022, AC0A0000, 8C0B0000 -> t0=0xFFFFFFFB, mem[0]=0x0000000A, t3=0x0000000A; lw takes exactly 5 cycles.
REQ-033 beq 11690002 with t3=10, t1=5 -> not taken, pc=+4 after 3 cycles; with t3=t1=5 -> pc=old+12.
REQ-034 Word 08000000 at address 0 after program -> pc returns to 0, retired pulses every 3 cycles.
REQ-035 Assert reset during MEM_WR of sw -> memory unchanged, pc=PC_RESET, all registers 0, halt=0 with clk stopped.
REQ-036 Word 0x0000002A (slt $0,$0,$0) -> HALT without MIPS_MC_SLT_EN; with it, 4-cycle retire and continue.
